// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the result UART transmitter: FSM encoding and frame constants.
// No logic, no latency; no flow control.
// Imported by the top, the FIFO and the bench.
package result_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int         FRAME_BITS = 10;
    localparam logic [3:0] ASCII_HI   = 4'h3;

    // Result nibble mapped onto ASCII '0'..'?'
    function automatic logic [7:0] to_ascii(input logic [3:0] val);
        return {ASCII_HI, val};
    endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Result strobe bus from the processor into the UART transmitter.
// No latency; no backpressure (results arrive as single-cycle strobes).
// master drives, slave samples.
interface result_uart_tx_if;
    logic [3:0] result;
    logic       result_valid;

    modport master (output result, output result_valid);
    modport slave  (input  result, input  result_valid);
endinterface

// File: rtl/result_uart_tx_fifo.sv
// Generic FIFO: circular buffer with wrapping pointers and an occupancy count.
// Latency: a pushed entry is visible at dout_o the cycle after the push.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
module result_fifo
    import result_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              din_i,
    output logic [WIDTH-1:0]              dout_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en;

    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
    assign wr_en = push_i && (!full_o || pop_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/result_uart_tx.sv
// Buffers 4-bit results and sends each as an ASCII byte in a 10-bit 8N1 frame on tx_o.
// Latency: result strobed in cycle N gives the start bit on tx_o from cycle N+2.
// Backpressure: none upstream; a result arriving while the buffer is full is dropped and flagged.
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    result_uart_tx_if.slave        in_if,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   fifo_full_o,
    output logic                   overflow_o
);
    tx_state_e  state_q, state_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] data_q, data_d;
    logic       tx_q, tx_d;
    logic       overflow_q, overflow_d;

    logic                        pop;
    logic [3:0]                  fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        bit_end;
    logic [2:0]                  nxt_idx;

    result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (4)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_if.result_valid),
        .pop_i   (pop),
        .din_i   (in_if.result),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_end = (clk_cnt_q == 8'(CLKS_PER_BIT - 1));
    assign nxt_idx = bit_idx_q + 3'd1;

    // tx_d is decided together with the state so tx_q changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        if (state_q != IDLE) clk_cnt_d = bit_end ? 8'd0 : clk_cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_d   = START;
                    data_d    = to_ascii(fifo_dout);
                    tx_d      = 1'b0;
                    clk_cnt_d = 8'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = nxt_idx;
                        tx_d      = data_q[nxt_idx];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                        data_d  = to_ascii(fifo_dout);
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign overflow_d = overflow_q | (in_if.result_valid & fifo_full & ~pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= 8'd0;
            bit_idx_q  <= 3'd0;
            data_q     <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_o        = tx_q;
    assign busy_o      = (state_q != IDLE) || (fifo_count != '0);
    assign fifo_full_o = fifo_full;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: directed scenarios plus random strobes against a queue-based model.
// The model tracks buffered results and cycles left in the frame on the wire.
module tb_result_uart_tx;
    import result_uart_tx_pkg::*;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy, full, ovf;

    result_uart_tx_if bus ();

    result_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (bus),
        .tx_o        (tx),
        .busy_o      (busy),
        .fifo_full_o (full),
        .overflow_o  (ovf)
    );

    always #5 clk = ~clk;

    logic [3:0] m_q [$];
    int         m_rem;
    logic [7:0] m_byte;
    bit         m_ovf;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_tx();
        int pos, b;
        if (m_rem == 0) return 1'b1;
        pos = FRAME_CYC - m_rem;
        b   = pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_rem = 0;
        m_ovf = 1'b0;
    endtask

    // One rising edge: a frame can start when the line is idle or on its last cycle.
    task automatic model_edge(input bit v, input logic [3:0] r);
        bit pop;
        pop = (m_q.size() != 0) && (m_rem <= 1);
        if (m_rem > 0) m_rem--;
        if (pop) begin
            m_byte = 8'h30 + {4'h0, m_q.pop_front()};
            m_rem  = FRAME_CYC;
        end
        if (v) begin
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else                    m_ovf = 1'b1;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".tx"},   tx,   m_tx());
        chk({tag, ".busy"}, busy, (m_rem > 0) || (m_q.size() > 0));
        chk({tag, ".full"}, full, m_q.size() == DEPTH);
        chk({tag, ".ovf"},  ovf,  m_ovf);
    endtask

    // Called at a negedge; drives one cycle of input and returns at the next negedge.
    task automatic step(input bit v, input logic [3:0] r, input string tag);
        bus.result_valid = v;
        bus.result       = r;
        @(posedge clk);
        model_edge(v, r);
        #1;
        check_outs(tag);
        @(negedge clk);
        bus.result_valid = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n            = 1'b0;
        bus.result_valid = 1'b0;
        #1;
        chk({tag, ".rst_tx"},   tx,   1'b1);
        chk({tag, ".rst_busy"}, busy, 1'b0);
        chk({tag, ".rst_full"}, full, 1'b0);
        chk({tag, ".rst_ovf"},  ovf,  1'b0);
        model_clear();
        @(posedge clk);
        #1;
        chk({tag, ".rst_hold_tx"}, tx, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int   burst;
        bit   found;
        bit   v;

        bus.result_valid = 1'b0;
        bus.result       = 4'h0;
        model_clear();
        m_byte = 8'h00;

        @(negedge clk);
        chk("init.tx",   tx,   1'b1);
        chk("init.busy", busy, 1'b0);
        chk("init.full", full, 1'b0);
        chk("init.ovf",  ovf,  1'b0);
        rst_n = 1'b1;

        step(1'b1, 4'd5, "single");
        idle(45, "single");

        for (int i = 0; i < 3; i++) step(1'b1, 4'(i), "b2b");
        idle(125, "b2b");

        for (int i = 1; i <= 6; i++) step(1'b1, 4'(i), "ovfl");
        chk("ovfl.flag", ovf, 1'b1);
        idle(210, "ovfl");

        do_reset("popcyc");
        for (int i = 0; i < 5; i++) step(1'b1, 4'(7 + i), "popcyc");
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_rem == 1 && m_q.size() == DEPTH) found = 1'b1;
            else step(1'b0, 4'h0, "popcyc");
        end
        chk("popcyc.reached", found, 1'b1);
        step(1'b1, 4'hA, "popcyc");
        chk("popcyc.still_full", full, 1'b1);
        chk("popcyc.no_ovf",     ovf,  1'b0);
        idle(220, "popcyc");

        step(1'b1, 4'd0, "midrst");
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_rem == FRAME_CYC - 17) found = 1'b1;
            else step(1'b0, 4'h0, "midrst");
        end
        chk("midrst.reached", found, 1'b1);
        chk("midrst.line_low", tx, 1'b0);
        do_reset("midrst");
        step(1'b1, 4'd9, "after_rst");
        idle(45, "after_rst");

        step(1'b1, 4'd15, "hi_nib");
        idle(45, "hi_nib");
        step(1'b1, 4'd0, "lo_nib");
        idle(45, "lo_nib");

        burst = 0;
        for (int i = 0; i < 1500; i++) begin
            if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(3, 8);
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rnd");
                burst = 0;
            end
            v = (burst > 0) || ($urandom_range(0, 29) == 0);
            if (burst > 0) burst--;
            step(v, 4'($urandom), "rnd");
        end
        idle(250, "drain");
        chk("drain.busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
